// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA output stage: the 4x4 ordered-dither
// (Bayer) threshold table, threshold-to-offset scaling and the sync/DE bundle type.
// Latency: n/a (package). Backpressure: n/a (package).
package vga_pkg;

  // Sync and data-enable travel together through the pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } vga_ctl_t;

  // Value held in the control pipeline while reset is asserted: syncs inactive
  // high, no active video.
  localparam vga_ctl_t CTL_RESET = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

  // 4x4 Bayer matrix, row-major, entry idx = {y[1:0], x[1:0]} at bits [4*idx +: 4].
  // Rows: {0,8,2,10} {12,4,14,6} {3,11,1,9} {15,7,13,5}.
  localparam logic [63:0] BAYER_4X4 = 64'h5D7F_91B3_6E4C_A280;

  function automatic logic [3:0] bayer_thresh(input logic [3:0] idx);
    return BAYER_4X4[{idx, 2'b00} +: 4];
  endfunction

  // Scale a 4-bit threshold onto the span of the dropped LSBs so the dither
  // offset always stays below one output LSB.
  function automatic logic [31:0] bayer_offset(input logic [3:0] t, input int drop);
    logic [31:0] tw;
    tw = {28'd0, t};
    if (drop >= 4) begin
      return tw << (drop - 4);
    end else if (drop > 0) begin
      return tw >> (4 - drop);
    end else begin
      return 32'd0;
    end
  endfunction

endpackage

// File: rtl/vga_dither_chan.sv
// One colour channel of the VGA output stage: add dither offset, saturate on
// carry, truncate to DAC width, blank outside active video, register.
// Latency: 1 clock (pipeline stage 2). Backpressure: none, free-running.
// Ports: clk_i/rst_ni clock and active-low async reset; de_i stage-1 data
// enable; t_i stage-1 Bayer threshold; pix_i stage-1 full-depth colour;
// col_o registered DAC colour.
// Build option: VGA_OUT_STAGE_DITHER_EN enables the dither/saturate path;
// otherwise the channel is a plain truncation and t_i is ignored.
module vga_dither_chan
  import vga_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                de_i,
  input  logic [3:0]          t_i,
  input  logic [IN_BITS-1:0]  pix_i,
  output logic [OUT_BITS-1:0] col_o
);

  localparam int DROP = IN_BITS - OUT_BITS;

  logic [OUT_BITS-1:0] quant;
  logic [OUT_BITS-1:0] col_d;
  logic [OUT_BITS-1:0] col_q;

`ifdef VGA_OUT_STAGE_DITHER_EN
  logic [IN_BITS-1:0] offset;
  logic [IN_BITS:0]   sum;
  logic               unused_sum;

  always_comb begin
    offset = IN_BITS'(bayer_offset(t_i, DROP));
    // One extra bit catches the carry so bright pixels clamp instead of wrapping.
    sum    = {1'b0, pix_i} + {1'b0, offset};
    quant  = sum[IN_BITS-1:DROP];
    if (sum[IN_BITS]) begin
      quant = '1;
    end
  end

  // Low bits of the sum are intentionally discarded by truncation.
  assign unused_sum = ^sum;
`else
  logic unused_in;

  assign quant     = pix_i[IN_BITS-1:DROP];
  assign unused_in = ^{t_i, pix_i};
`endif

  // Blanking: DAC must see black outside active video whatever the source drives.
  assign col_d = de_i ? quant : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  assign col_o = col_q;

endmodule

// File: rtl/vga_out_stage.sv
// VGA output stage: reduces full-depth pixel colour to DAC width with optional
// 4x4 ordered dither, and keeps syncs/DE aligned with the colour.
// Latency: 2 clocks, every input to its output. Backpressure: none, free-running.
// Ports: CLK_25MHZ pixel clock; RESET_N async active-low reset (release
// synchronised internally); IN_HSYNC/IN_VSYNC/IN_DE raw timing; IN_RED/GREEN/BLUE
// IN_BITS colour; VGA_HSYNC/VSYNC/DE delayed timing; VGA_RED/GREEN/BLUE OUT_BITS
// colour. Build option: VGA_OUT_STAGE_DITHER_EN adds the X/Y pixel counters and
// Bayer dither; without it colour is plainly truncated.
module vga_out_stage
  import vga_pkg::*;
#(
  parameter int IN_BITS      = 8,
  parameter int OUT_BITS     = 4,
  parameter int VSYNC_ACTIVE = 0
) (
  input  logic                CLK_25MHZ,
  input  logic                RESET_N,
  input  logic                IN_HSYNC,
  input  logic                IN_VSYNC,
  input  logic                IN_DE,
  input  logic [IN_BITS-1:0]  IN_RED,
  input  logic [IN_BITS-1:0]  IN_GREEN,
  input  logic [IN_BITS-1:0]  IN_BLUE,
  output logic                VGA_HSYNC,
  output logic                VGA_VSYNC,
  output logic [OUT_BITS-1:0] VGA_RED,
  output logic [OUT_BITS-1:0] VGA_GREEN,
  output logic [OUT_BITS-1:0] VGA_BLUE,
  output logic                VGA_DE
);

  if (OUT_BITS < 1 || OUT_BITS > IN_BITS) begin : g_bad_cfg
    $error("vga_out_stage: OUT_BITS must lie in 1..IN_BITS");
  end

  localparam logic VS_ACT = (VSYNC_ACTIVE != 0);

  // Reset: asserts asynchronously, releases two clocks after RESET_N rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Stage 1: register timing, colour and the threshold for this pixel.
  vga_ctl_t           ctl_d;
  vga_ctl_t           ctl_q;
  vga_ctl_t           ctl2_q;
  logic [IN_BITS-1:0] red_q;
  logic [IN_BITS-1:0] green_q;
  logic [IN_BITS-1:0] blue_q;
  logic [3:0]         t_d;
  logic [3:0]         t_q;

  assign ctl_d = '{hsync: IN_HSYNC, vsync: IN_VSYNC, de: IN_DE};

`ifdef VGA_OUT_STAGE_DITHER_EN
  logic [1:0] x_d;
  logic [1:0] x_q;
  logic [1:0] y_d;
  logic [1:0] y_q;
  logic       vs_prev_q;

  // Only the two LSBs of X/Y address the matrix, so 2-bit counters wrapping
  // freely give identical thresholds to wider ones.
  always_comb begin
    x_d = IN_DE ? x_q + 2'd1 : 2'd0;
    y_d = y_q;
    if (IN_VSYNC == VS_ACT && vs_prev_q != VS_ACT) begin
      y_d = 2'd0;
    end else if (ctl_q.de && !IN_DE) begin
      // ctl_q.de is last cycle's IN_DE: this is the end-of-line edge.
      y_d = y_q + 2'd1;
    end
    // Threshold uses the pre-increment X, so the first active pixel is X=0.
    t_d = bayer_thresh({y_q, x_q});
  end

  always_ff @(posedge CLK_25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= 2'd0;
      y_q       <= 2'd0;
      vs_prev_q <= ~VS_ACT;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      vs_prev_q <= IN_VSYNC;
    end
  end
`else
  logic unused_vs;

  assign t_d       = 4'd0;
  assign unused_vs = VS_ACT;
`endif

  always_ff @(posedge CLK_25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q   <= CTL_RESET;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      t_q     <= 4'd0;
    end else begin
      ctl_q   <= ctl_d;
      red_q   <= IN_RED;
      green_q <= IN_GREEN;
      blue_q  <= IN_BLUE;
      t_q     <= t_d;
    end
  end

  // Stage 2: timing is delayed once more; colour is finished in the channels.
  always_ff @(posedge CLK_25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      ctl2_q <= CTL_RESET;
    end else begin
      ctl2_q <= ctl_q;
    end
  end

  vga_dither_chan #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_chan_red (
    .clk_i  (CLK_25MHZ),
    .rst_ni (rst_n),
    .de_i   (ctl_q.de),
    .t_i    (t_q),
    .pix_i  (red_q),
    .col_o  (VGA_RED)
  );

  vga_dither_chan #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_chan_green (
    .clk_i  (CLK_25MHZ),
    .rst_ni (rst_n),
    .de_i   (ctl_q.de),
    .t_i    (t_q),
    .pix_i  (green_q),
    .col_o  (VGA_GREEN)
  );

  vga_dither_chan #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_chan_blue (
    .clk_i  (CLK_25MHZ),
    .rst_ni (rst_n),
    .de_i   (ctl_q.de),
    .t_i    (t_q),
    .pix_i  (blue_q),
    .col_o  (VGA_BLUE)
  );

  assign VGA_HSYNC = ctl2_q.hsync;
  assign VGA_VSYNC = ctl2_q.vsync;
  assign VGA_DE    = ctl2_q.de;

endmodule

// File: tb/tb_vga_out_stage.sv
// Directed bench for vga_out_stage (IN_BITS=8, OUT_BITS=4, active-low vsync).
// Expected colours are hand-computed for both the dither and truncation builds.
module tb_vga_out_stage;

`ifdef VGA_OUT_STAGE_DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs    = 1'b1;
  logic       vs    = 1'b1;
  logic       de    = 1'b0;
  logic [7:0] r     = 8'h00;
  logic [7:0] g     = 8'h00;
  logic [7:0] b     = 8'h00;

  logic       vga_hs;
  logic       vga_vs;
  logic       vga_de;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } obs_t;

  obs_t  exp_q[$];
  int    due_q[$];
  string tag_q[$];

  always #20 clk = ~clk;

  vga_out_stage #(.IN_BITS(8), .OUT_BITS(4), .VSYNC_ACTIVE(0)) dut (
    .CLK_25MHZ (clk),
    .RESET_N   (rst_n),
    .IN_HSYNC  (hs),
    .IN_VSYNC  (vs),
    .IN_DE     (de),
    .IN_RED    (r),
    .IN_GREEN  (g),
    .IN_BLUE   (b),
    .VGA_HSYNC (vga_hs),
    .VGA_VSYNC (vga_vs),
    .VGA_RED   (vga_r),
    .VGA_GREEN (vga_g),
    .VGA_BLUE  (vga_b),
    .VGA_DE    (vga_de)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and check every vector now two clocks old.
  task automatic tick();
    obs_t  o;
    obs_t  e;
    string t;
    @(negedge clk);
    cyc++;
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      void'(due_q.pop_front());
      o = '{hs: vga_hs, vs: vga_vs, de: vga_de, r: vga_r, g: vga_g, b: vga_b};
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed hs=%b vs=%b de=%b r=%h g=%h b=%h expected hs=%b vs=%b de=%b r=%h g=%h b=%h",
               t, o.hs, o.vs, o.de, o.r, o.g, o.b, e.hs, e.vs, e.de, e.r, e.g, e.b);
      end
    end
  endtask

  // Drive one pixel clock of input; its outputs are due two clocks later.
  task automatic px(input string tag, input logic ihs, input logic ivs, input logic ide,
                    input logic [7:0] ir, input logic [7:0] ig, input logic [7:0] ib,
                    input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    hs = ihs; vs = ivs; de = ide; r = ir; g = ig; b = ib;
    exp_q.push_back('{hs: ihs, vs: ivs, de: ide, r: er, g: eg, b: eb});
    due_q.push_back(cyc + 2);
    tag_q.push_back(tag);
    tick();
  endtask

  initial begin
    // Reset held with live-looking inputs: outputs must stay in the idle state.
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b1; r = 8'hFF; g = 8'hFF; b = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_red", 8'(vga_r),  8'h00);
    chk("rst_de",  8'(vga_de), 8'h00);
    chk("rst_hs",  8'(vga_hs), 8'h01);
    chk("rst_vs",  8'(vga_vs), 8'h01);

    // Release: two clocks of synchroniser, then two clocks of pipeline.
    hs = 1'b1; vs = 1'b1; de = 1'b1; r = 8'h00; g = 8'h00; b = 8'h00;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_hold_de", 8'(vga_de), 8'h00);
    @(negedge clk);
    chk("rel_first_de", 8'(vga_de), 8'h01);

    //  tag          hs    vs    de    red    green  blue   exp r / g / b
    px("idle0",      1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0);
    px("vs_pulse",   1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0);
    px("blank",      1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 4'h0, 4'h0, 4'h0);
    // Row Y=0, thresholds 0,8,2,10.
    px("row0_x0",    1'b1, 1'b1, 1'b1, 8'h18, 8'h9C, 8'h00, 4'h1, 4'h9, 4'h0);
    px("row0_x1",    1'b1, 1'b1, 1'b1, 8'h18, 8'h9C, 8'h00,
       DITH ? 4'h2 : 4'h1, DITH ? 4'hA : 4'h9, 4'h0);
    px("row0_x2",    1'b1, 1'b1, 1'b1, 8'h18, 8'h9C, 8'h00, 4'h1, 4'h9, 4'h0);
    px("row0_x3",    1'b1, 1'b1, 1'b1, 8'h18, 8'h9C, 8'h00,
       DITH ? 4'h2 : 4'h1, DITH ? 4'hA : 4'h9, 4'h0);
    // Three-clock hsync pulse must reappear two clocks later, same width.
    px("hs_pulse0",  1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0);
    px("hs_pulse1",  1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0);
    px("hs_pulse2",  1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0);
    px("hs_end",     1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0);
    // Y=1, X=0: T=12, 0x34+0xC=0x40.
    px("row1_x0",    1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h34, 4'h0, 4'h0, DITH ? 4'h4 : 4'h3);
    px("row1_end",   1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0);
    // Y=2, X=0: T=3, 0x0D+3=0x10.
    px("row2_x0",    1'b1, 1'b1, 1'b1, 8'h0D, 8'h00, 8'h00, DITH ? 4'h1 : 4'h0, 4'h0, 4'h0);
    px("row2_end",   1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0);
    // Y=3, X=0: T=15, 0xFE+0xF carries and must clamp, not wrap.
    px("row3_sat",   1'b1, 1'b1, 1'b1, 8'h00, 8'hFE, 8'h00, 4'h0, 4'hF, 4'h0);
    // Y=3, X=1: T=7, 0xF9+7=0x100 carries; 0x9C+7=0xA3.
    px("row3_x1",    1'b1, 1'b1, 1'b1, 8'h9C, 8'hF9, 8'h00, DITH ? 4'hA : 4'h9, 4'hF, 4'h0);
    px("row3_end",   1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0);
    tick();
    tick();

    // Mid-frame reset must clear in-flight pixels immediately.
    hs = 1'b0; de = 1'b1; r = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_red", 8'(vga_r),  8'h0F);
    chk("pre_rst_de",  8'(vga_de), 8'h01);
    chk("pre_rst_hs",  8'(vga_hs), 8'h00);
    #5;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_red", 8'(vga_r),  8'h00);
    chk("mid_rst_de",  8'(vga_de), 8'h00);
    chk("mid_rst_hs",  8'(vga_hs), 8'h01);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_out_stage.md
VGA_OUT_STAGE -- requirements
Module: vga_out_stage

Interface
REQ-001 SHALL have parameter IN_BITS, default 8: input colour bits per channel.
REQ-002 SHALL have parameter OUT_BITS, default 4: DAC bits per channel; legal range 1..IN_BITS.
REQ-003 SHALL have parameter VSYNC_ACTIVE, default 0: asserted level of IN_VSYNC.
REQ-004 SHALL have port CLK_25MHZ  in  1  pixel clock; the only clock.
REQ-005 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports IN_HSYNC and IN_VSYNC  in  1 each  raw syncs from the video generator.
REQ-007 SHALL have port IN_DE  in  1  active-video (data enable).
REQ-008 SHALL have ports IN_RED, IN_GREEN, IN_BLUE  in  IN_BITS each  full-depth pixel colour.
REQ-009 SHALL have ports VGA_HSYNC, VGA_VSYNC  out  1 each  delayed syncs.
REQ-010 SHALL have ports VGA_RED, VGA_GREEN, VGA_BLUE  out  OUT_BITS each  DAC colour.
REQ-011 SHALL have port VGA_DE  out  1  delayed data enable.

Function
REQ-012 SHALL use a fixed latency of 2 clocks from any input to its output; syncs, DE and colour stay aligned.
REQ-013 SHALL keep a column counter X: increments on each IN_DE=1 cycle; clears on the cycle after IN_DE falls.
REQ-014 SHALL keep a row counter Y: increments on each IN_DE falling edge; clears when IN_VSYNC first equals VSYNC_ACTIVE.
REQ-015 SHALL let X and Y wrap silently; only bits [1:0] of each are used.
REQ-016 SHALL take threshold T (0..15) from a 4x4 Bayer matrix indexed by {Y[1:0],X[1:0]}.
REQ-017 SHALL set drop width D=IN_BITS-OUT_BITS; offset = T<<(D-4) if D>=4, T>>(4-D) if 0<D<4, 0 if D=0.
REQ-018 SHALL compute per channel sum = IN + offset in IN_BITS+1 bits; on carry-out, output all ones (saturate), else output sum[IN_BITS-1:D].
REQ-019 SHALL force colour outputs to 0 whenever delayed DE is 0 (blanking), regardless of input colour.
REQ-020 SHALL pass input colour unchanged when D=0.
REQ-021 SHALL stage the pipeline as: stage 1 registers inputs and T; stage 2 adds, saturates, truncates and blanks.
REQ-022 SHALL stop compilation (elaboration error) if OUT_BITS<1 or OUT_BITS>IN_BITS.

Reset
REQ-023 SHALL, while RESET_N=0, drive VGA_RED/GREEN/BLUE=0, VGA_DE=0, and VGA_HSYNC=VGA_VSYNC=1 (inactive, for active-low syncs).
REQ-024 SHALL clear X, Y and all pipeline registers asynchronously on reset assertion; reset mid-frame discards in-flight pixels.
REQ-025 SHALL release reset synchronously via an internal 2-flop synchroniser; the first valid output appears 2 clocks after the first post-release input.

Configuration
REQ-026 SHALL honour macro VGA_OUT_STAGE_DITHER_EN: defined = Bayer dither per REQ-016..018; undefined = offset forced to 0 (plain truncation, no saturation path), X/Y counters removed, latency still 2.

Structure
REQ-027 SHALL place the 4x4 Bayer table constant and the threshold-scaling function in shared package vga_pkg.
REQ-028 SHALL implement one sub-module, vga_dither_chan, instantiated three times (R,G,B), holding the per-channel add/saturate/truncate/blank logic.

Verification
REQ-029 SHALL check reset: RESET_N=0 with IN_RED=0xFF, IN_DE=1 -> VGA_RED=0, VGA_DE=0, syncs=1.
REQ-030 SHALL check latency: IN_HSYNC pulse at cycle n -> VGA_HSYNC pulse at cycle n+2, same width.
REQ-031 SHALL check dither with DITHER_EN, IN_BITS=8, OUT_BITS=4: IN_RED=0x18 across X=0..3, Y=0 -> VGA_RED 0x1,0x2,0x1,0x2 (T=0,8,2,10).
REQ-032 SHALL check saturation: IN_GREEN=0xFE at T=15 -> VGA_GREEN=0xF, no wrap to 0.
REQ-033 SHALL check blanking: IN_DE=0 with IN_BLUE=0xFF -> VGA_BLUE=0 two cycles later.
REQ-034 SHALL check truncation build (macro undefined): IN_RED=0x9C -> VGA_RED=0x9 at every X/Y.
